fifo_drain_reader: RTL and testbench

- Read-side master for the team's synchronous `fifo` block. It sits on the consumer end of the FIFO's `pop`/`empty`/`data_out` port group.
- Issues pops only when a pop is legal and there is room, compensating for the FIFO's 1-cycle registered read latency.
- Re-presents the popped words on a valid/ready stream through a small skid buffer.
- Provides run/drain control, a popped-word counter and a sticky protocol-error flag.

---
 rtl/fifo_drain_reader.sv | 159 +++++++++++++++
 tb/tb_fifo_drain_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_reader.sv
// Consumer-side master for the synchronous fifo block: pops with credit-based flow
// control, absorbs the 1-cycle FIFO read latency and re-presents words on a valid/ready stream.
module fifo_drain_reader #(
    parameter int DATA_W = 16,
    parameter int SKID   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              drain_req,
    output logic              fifo_pop,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    input  logic              fifo_pop_err_on_empty,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              drain_done,
    output logic              busy,
    output logic [CNT_W-1:0]  popped_count,
    output logic              err_sticky
);

    localparam int PTR_W = (SKID > 1) ? $clog2(SKID) : 1;
    localparam int OCC_W = $clog2(SKID + 1) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic              inflight;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  buf_count;
    logic [OCC_W-1:0]  occupancy;
    logic [DATA_W-1:0] skid_mem [SKID];
    logic              capture;
    logic              dequeue;
    logic              credit_ok;
    logic              active;
    logic              drain_complete;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(SKID - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Credit counts the word still in the FIFO read stage, so the buffer can never overflow
    // even though the pop decision ignores m_ready.
    assign occupancy      = buf_count + OCC_W'(inflight);
    assign credit_ok      = occupancy < OCC_W'(SKID);
    assign active         = (state == RUN) || (state == DRAIN);
    assign fifo_pop       = active && !fifo_empty && credit_ok;

    assign capture        = inflight;
    assign m_valid        = (buf_count != '0);
    assign m_data         = skid_mem[rd_ptr];
    assign dequeue        = m_valid && m_ready;

    assign drain_complete = fifo_empty && !inflight && (buf_count == '0) && !fifo_pop;
    assign busy           = (state != IDLE) || inflight || (buf_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (drain_req) begin
                    next_state = DRAIN;
                end else if (enable) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (drain_req) begin
                    next_state = DRAIN;
                end else if (!enable) begin
                    next_state = IDLE;
                end
            end
            DRAIN: begin
                if (drain_complete) begin
                    next_state = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight     <= 1'b0;
            popped_count <= '0;
            err_sticky   <= 1'b0;
        end else begin
            inflight <= fifo_pop;
            if (fifo_pop) begin
                popped_count <= popped_count + CNT_W'(1);
            end
            if (fifo_pop_err_on_empty) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // Circular skid buffer; a word read while inflight is set is the FIFO's registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            buf_count <= '0;
            for (int i = 0; i < SKID; i++) begin
                skid_mem[i] <= '0;
            end
        end else begin
            if (capture) begin
                skid_mem[wr_ptr] <= fifo_data_out;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (dequeue) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({capture, dequeue})
                2'b10:   buf_count <= buf_count + OCC_W'(1);
                2'b01:   buf_count <= buf_count - OCC_W'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        buf_count <= OCC_W'(SKID));

    a_pop_legal: assert property (@(posedge clk) disable iff (rst)
        fifo_pop |-> !fifo_empty);

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Self-checking bench for fifo_drain_reader: models the FIFO and the words owed to the
// stream as queues, and checks directed tables plus a randomized run against that model.
module tb_fifo_drain_reader;

    localparam int DATA_W = 16;
    localparam int SKID   = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              drain_req;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_pop_err_on_empty;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              drain_done;
    logic              busy;
    logic [CNT_W-1:0]  popped_count;
    logic              err_sticky;

    fifo_drain_reader #(
        .DATA_W(DATA_W),
        .SKID  (SKID),
        .CNT_W (CNT_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .drain_req            (drain_req),
        .fifo_pop             (fifo_pop),
        .fifo_empty           (fifo_empty),
        .fifo_data_out        (fifo_data_out),
        .fifo_pop_err_on_empty(fifo_pop_err_on_empty),
        .m_valid              (m_valid),
        .m_data               (m_data),
        .m_ready              (m_ready),
        .drain_done           (drain_done),
        .busy                 (busy),
        .popped_count         (popped_count),
        .err_sticky           (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              en;
        logic              rdy;
        logic              exp_pop;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t stream_tbl [12];
    vec_t bp_tbl     [10];

    int checks = 0;
    int errors = 0;

    // src_q is the FIFO contents; owed holds words popped but not yet handed downstream.
    logic [DATA_W-1:0] src_q [$];
    logic [DATA_W-1:0] owed  [$];
    int   mode;
    int   delivered;
    int   drain_pulses;
    int   cyc;
    int   last_xfer_cyc;
    int   done_cyc;
    logic prev_stall;
    logic [DATA_W-1:0] prev_data;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic rdy, input logic drq);
        enable    = en;
        m_ready   = rdy;
        drain_req = drq;
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        src_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Checks the cycle's handshake against the model, crosses the clock edge and updates the model.
    task automatic finish_cycle();
        logic v, r, p, e, dd, b, rst_now, complete, exp_pop;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] w;
        int next_mode;
        v = m_valid; r = m_ready; p = fifo_pop; e = fifo_empty;
        dd = drain_done; b = busy; d = m_data; rst_now = rst;
        complete  = (mode == 2) && e && (owed.size() == 0);
        next_mode = mode;
        if (!rst_now) begin
            exp_pop = (mode != 0) && !e && (owed.size() < SKID);
            check_output("pop_rule", 32'(p), 32'(exp_pop));
            if (p) check_output("pop_while_empty", 32'(e), 32'd0);
            check_output("drain_done", 32'(dd), 32'(complete));
            check_output("busy", 32'(b), 32'((mode != 0) || (owed.size() != 0)));
            if (prev_stall && v) check_output("m_data_stable", 32'(d), 32'(prev_data));
            if (v && r) begin
                if (owed.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h expected no word", d);
                end else begin
                    check_output("m_data_order", 32'(d), 32'(owed[0]));
                end
            end
            if (dd) begin
                drain_pulses++;
                done_cyc = cyc;
            end
        end
        if (rst_now) begin
            next_mode = 0;
        end else begin
            case (mode)
                0: if (drain_req) next_mode = 2; else if (enable)  next_mode = 1;
                1: if (drain_req) next_mode = 2; else if (!enable) next_mode = 0;
                default: if (complete) next_mode = 0;
            endcase
        end
        @(posedge clk);
        #1;
        if (rst_now) begin
            owed.delete();
        end else begin
            if (v && r) begin
                if (owed.size() != 0) void'(owed.pop_front());
                delivered++;
                last_xfer_cyc = cyc;
            end
            if (p && (src_q.size() != 0)) begin
                w = src_q.pop_front();
                fifo_data_out = w;
                owed.push_back(w);
            end
        end
        fifo_empty = (src_q.size() == 0);
        prev_stall = v && !r && !rst_now;
        prev_data  = d;
        mode       = next_mode;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        finish_cycle();
        finish_cycle();
        rst = 1'b0;
        src_q.delete();
        fifo_empty   = 1'b1;
        delivered    = 0;
        drain_pulses = 0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int total;
        int k;

        for (int i = 0; i < 12; i++) begin
            stream_tbl[i] = '{en: 1'b1, rdy: 1'b1, exp_pop: (i >= 1 && i <= 8),
                              exp_valid: (i >= 3 && i <= 10), exp_data: DATA_W'(i - 2)};
        end
        for (int i = 0; i < 10; i++) begin
            bp_tbl[i] = '{en: 1'b1, rdy: 1'b0, exp_pop: (i >= 1 && i <= 3),
                          exp_valid: (i >= 3), exp_data: DATA_W'(1)};
        end

        rst = 1'b1; enable = 1'b0; drain_req = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_data_out = '0; fifo_pop_err_on_empty = 1'b0;
        mode = 0; delivered = 0; drain_pulses = 0; cyc = 0;
        last_xfer_cyc = -1; done_cyc = -1; prev_stall = 1'b0; prev_data = '0;

        // Reset with words waiting in the FIFO, then idle with enable low.
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_word(DATA_W'(16'h0100 + i));
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0);
            check_output("reset_m_valid", 32'(m_valid), 32'd0);
            check_output("reset_count", 32'(popped_count), 32'd0);
            check_output("reset_err", 32'(err_sticky), 32'd0);
            finish_cycle();
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            check_output("idle_pop", 32'(fifo_pop), 32'd0);
            check_output("idle_m_valid", 32'(m_valid), 32'd0);
            check_output("idle_count", 32'(popped_count), 32'd0);
            finish_cycle();
        end

        // Streaming at full rate.
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(DATA_W'(i));
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(stream_tbl[i].en, stream_tbl[i].rdy, 1'b0);
            check_output("stream_pop", 32'(fifo_pop), 32'(stream_tbl[i].exp_pop));
            check_output("stream_valid", 32'(m_valid), 32'(stream_tbl[i].exp_valid));
            if (stream_tbl[i].exp_valid) check_output("stream_data", 32'(m_data), 32'(stream_tbl[i].exp_data));
            finish_cycle();
        end
        check_output("stream_count", 32'(popped_count), 32'd8);
        check_output("stream_delivered", 32'(delivered), 32'd8);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        finish_cycle();
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("stream_busy_end", 32'(busy), 32'd0);
        finish_cycle();

        // Back-pressure: credit limit holds pops at SKID, then release.
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(DATA_W'(i));
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(bp_tbl[i].en, bp_tbl[i].rdy, 1'b0);
            check_output("bp_pop", 32'(fifo_pop), 32'(bp_tbl[i].exp_pop));
            check_output("bp_valid", 32'(m_valid), 32'(bp_tbl[i].exp_valid));
            if (bp_tbl[i].exp_valid) check_output("bp_data", 32'(m_data), 32'(bp_tbl[i].exp_data));
            finish_cycle();
        end
        check_output("bp_count", 32'(popped_count), 32'd3);
        for (k = 0; k < 40 && delivered < 8; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            finish_cycle();
        end
        check_output("bp_delivered", 32'(delivered), 32'd8);
        check_output("bp_fifo_left", 32'(src_q.size()), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        finish_cycle();

        // Drain with enable low.
        do_reset();
        for (int i = 0; i < 5; i++) push_word(DATA_W'(16'h00A0 + i));
        apply_stimulus(1'b0, 1'b1, 1'b1);
        finish_cycle();
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            finish_cycle();
        end
        check_output("drain_delivered", 32'(delivered), 32'd5);
        check_output("drain_pulses", 32'(drain_pulses), 32'd1);
        check_output("drain_done_timing", 32'(done_cyc), 32'(last_xfer_cyc + 1));
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("drain_busy_end", 32'(busy), 32'd0);
        finish_cycle();

        // Asynchronous reset with two buffered words and one in flight.
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(DATA_W'(16'h0200 + i));
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            finish_cycle();
        end
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("midrst_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_output("midrst_m_valid", 32'(m_valid), 32'd0);
        check_output("midrst_count", 32'(popped_count), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        finish_cycle();
        apply_stimulus(1'b0, 1'b1, 1'b0);
        finish_cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            check_output("midrst_no_stale", 32'(m_valid), 32'd0);
            finish_cycle();
        end
        for (k = 0; k < 30 && delivered < 5; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            finish_cycle();
        end
        check_output("midrst_delivered", 32'(delivered), 32'd5);
        check_output("midrst_recount", 32'(popped_count), 32'd5);

        // Sticky error flag.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("err_clear", 32'(err_sticky), 32'd0);
        fifo_pop_err_on_empty = 1'b1;
        finish_cycle();
        fifo_pop_err_on_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            check_output("err_sticky", 32'(err_sticky), 32'd1);
            finish_cycle();
        end
        do_reset();
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("err_after_rst", 32'(err_sticky), 32'd0);
        finish_cycle();

        // Counter wrap: 17 pops on a 4-bit counter.
        for (int i = 0; i < 17; i++) push_word(DATA_W'(16'h0300 + i));
        for (k = 0; k < 60 && delivered < 17; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            finish_cycle();
        end
        check_output("wrap_delivered", 32'(delivered), 32'd17);
        check_output("wrap_count", 32'(popped_count), 32'd1);

        // Randomized traffic, then a final drain to flush everything.
        do_reset();
        total = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                push_word(DATA_W'($urandom_range(0, 65535)));
                total++;
            end
            apply_stimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 49) == 0));
            finish_cycle();
        end
        apply_stimulus(1'b0, 1'b1, 1'b1);
        finish_cycle();
        for (k = 0; k < 100 && !(mode == 0 && owed.size() == 0); k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            finish_cycle();
        end
        check_output("rand_delivered", 32'(delivered), 32'(total));
        check_output("rand_count", 32'(popped_count), 32'(total % 16));
        check_output("rand_fifo_left", 32'(src_q.size()), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("rand_busy_end", 32'(busy), 32'd0);
        finish_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
